// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_pkg;

  localparam int unsigned IF_ADDR_W  = 32;
  localparam int unsigned IF_INSTR_W = 32;
  localparam int unsigned PC_INC     = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic                  valid;
    logic [IF_ADDR_W-1:0]  pc;
    logic [IF_INSTR_W-1:0] instr;
  } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush clears valid and wins over load; freeze blocks load.
module if_id_reg
  import if_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   i_load,
  input  logic   i_freeze,
  input  logic   i_flush,
  input  if_id_t i_d,
  output if_id_t o_q
);

  if_id_t r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (i_flush) begin
      r_q.valid <= 1'b0;
    end else if (i_load && !i_freeze) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/if_stage_unit.sv
// Instruction-fetch stage: PC, imem req/ack FSM, one-entry skid buffer, IF/ID register.
// Optional IF_PERF_CNT_EN adds saturating stall_cycles / flush_count outputs.
module if_stage_unit
  import if_pkg::*;
#(
  parameter int unsigned          ADDR_W   = IF_ADDR_W,
  parameter int unsigned          INSTR_W  = IF_INSTR_W,
  parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               hazard,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_addr,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               if_id_valid,
  output logic [ADDR_W-1:0]  if_id_pc,
  output logic [INSTR_W-1:0] if_id_instr
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]        stall_cycles,
  output logic [15:0]        flush_count
`endif
);

  fetch_state_t       r_state, w_state_nxt;
  logic [ADDR_W-1:0]  r_pc, w_pc_nxt;
  logic [ADDR_W-1:0]  r_drain_addr;
  logic [ADDR_W-1:0]  r_skid_pc;
  logic [INSTR_W-1:0] r_skid_instr;
  logic               w_drain_load;
  logic               w_skid_load;
  logic               w_ifid_load;
  logic               w_ifid_flush;
  logic [ADDR_W-1:0]  w_pc_inc;
  logic [ADDR_W-1:0]  w_skid_inc;
  if_id_t             w_ifid_d;
  if_id_t             w_ifid_q;

  assign w_pc_inc   = r_pc + ADDR_W'(PC_INC);
  assign w_skid_inc = r_skid_pc + ADDR_W'(PC_INC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drain_addr <= '0;
      r_skid_pc    <= '0;
      r_skid_instr <= '0;
    end else begin
      if (w_drain_load) r_drain_addr <= r_pc;
      if (w_skid_load) begin
        r_skid_pc    <= r_pc;
        r_skid_instr <= imem_rdata;
      end
    end
  end

  // The skid buffer is only consumed from HOLD, so leaving HOLD on a branch discards it.
  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_drain_load = 1'b0;
    w_skid_load  = 1'b0;
    w_ifid_load  = 1'b0;
    w_ifid_flush = 1'b0;
    w_ifid_d.valid = 1'b1;
    w_ifid_d.pc    = IF_ADDR_W'(w_pc_inc);
    w_ifid_d.instr = IF_INSTR_W'(imem_rdata);

    if (branch_taken) begin
      w_ifid_flush = 1'b1;
      w_pc_nxt     = branch_addr;
      unique case (r_state)
        IDLE:  w_state_nxt = FETCH;
        FETCH: begin
          if (!imem_ack) begin
            w_state_nxt  = DRAIN;
            w_drain_load = 1'b1;
          end
        end
        HOLD:  w_state_nxt = FETCH;
        DRAIN: if (imem_ack) w_state_nxt = FETCH;
        default: w_state_nxt = IDLE;
      endcase
    end else begin
      unique case (r_state)
        IDLE:  w_state_nxt = FETCH;
        FETCH: begin
          if (imem_ack) begin
            if (hazard) begin
              w_skid_load = 1'b1;
              w_state_nxt = HOLD;
            end else begin
              w_ifid_load = 1'b1;
              w_pc_nxt    = w_pc_inc;
            end
          end else if (!hazard) begin
            w_ifid_flush = 1'b1;
          end
        end
        HOLD: begin
          if (!hazard) begin
            w_ifid_load    = 1'b1;
            w_ifid_d.pc    = IF_ADDR_W'(w_skid_inc);
            w_ifid_d.instr = IF_INSTR_W'(r_skid_instr);
            w_pc_nxt       = w_pc_inc;
            w_state_nxt    = FETCH;
          end
        end
        DRAIN: if (imem_ack) w_state_nxt = FETCH;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  if_id_reg u_if_id_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (w_ifid_load),
    .i_freeze (hazard),
    .i_flush  (w_ifid_flush),
    .i_d      (w_ifid_d),
    .o_q      (w_ifid_q)
  );

  // DRAIN presents the address of the abandoned request until its ack arrives.
  assign imem_req    = (r_state == FETCH) || (r_state == DRAIN);
  assign imem_addr   = (r_state == DRAIN) ? r_drain_addr : r_pc;
  assign if_id_valid = w_ifid_q.valid;
  assign if_id_pc    = ADDR_W'(w_ifid_q.pc);
  assign if_id_instr = INSTR_W'(w_ifid_q.instr);

`ifdef IF_PERF_CNT_EN
  logic [31:0] r_stall_cycles;
  logic [15:0] r_flush_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      if (hazard && (r_state != IDLE) && (r_stall_cycles != '1))
        r_stall_cycles <= r_stall_cycles + 32'd1;
      if (branch_taken && (r_flush_count != '1))
        r_flush_count <= r_flush_count + 16'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign flush_count  = r_flush_count;
`endif

endmodule

// File: tb/tb_if_stage_unit.sv
// Self-checking bench for if_stage_unit: directed vector table, reset corner cases,
// then random stimulus against a behavioural fetch model.
module tb_if_stage_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hazard;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;
`ifdef IF_PERF_CNT_EN
  logic [31:0] stall_cycles;
  logic [15:0] flush_count;
`endif

  if_stage_unit #(.ADDR_W(32), .INSTR_W(32), .RESET_PC(32'h0)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .hazard       (hazard),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .if_id_valid  (if_id_valid),
    .if_id_pc     (if_id_pc),
    .if_id_instr  (if_id_instr)
`ifdef IF_PERF_CNT_EN
    ,
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
`endif
  );

  always #5 clk = ~clk;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", name, act, exp);
  endtask

  typedef struct {
    logic        hz;
    logic        br;
    logic [31:0] ba;
    logic        ack;
    logic [31:0] rd;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_v;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
  } vec_t;

  vec_t tbl[18];

  function automatic vec_t mk(logic hz, logic br, logic [31:0] ba, logic ack, logic [31:0] rd,
                              logic er, logic [31:0] ea, logic ev, logic [31:0] ep, logic [31:0] ei);
    vec_t v;
    v.hz = hz; v.br = br; v.ba = ba; v.ack = ack; v.rd = rd;
    v.e_req = er; v.e_addr = ea; v.e_v = ev; v.e_pc = ep; v.e_instr = ei;
    return v;
  endfunction

  task automatic drive(input logic hz, input logic br, input logic [31:0] ba,
                       input logic ack, input logic [31:0] rd);
    hazard = hz; branch_taken = br; branch_addr = ba; imem_ack = ack; imem_rdata = rd;
  endtask

  // Behavioural model: tracks what the fetch unit is doing with plain flags.
  logic        m_started, m_outstanding, m_held;
  logic [31:0] m_pc, m_drain_addr, m_bpc, m_binstr;
  logic        m_v;
  logic [31:0] m_ipc, m_instr;
  int unsigned m_stall, m_flush;

  task automatic model_reset();
    m_started = 0; m_outstanding = 0; m_held = 0;
    m_pc = 0; m_drain_addr = 0; m_bpc = 0; m_binstr = 0;
    m_v = 0; m_ipc = 0; m_instr = 0; m_stall = 0; m_flush = 0;
  endtask

  task automatic model_step(input logic hz, input logic br, input logic [31:0] ba,
                            input logic ack, input logic [31:0] rd);
    if (hz && m_started) m_stall++;
    if (br) m_flush++;
    if (!m_started) begin
      m_started = 1;
      if (br) begin m_pc = ba; m_v = 0; end
    end else if (br) begin
      m_v = 0;
      if (m_held) m_held = 0;
      else if (m_outstanding) begin
        if (ack) m_outstanding = 0;
      end else if (!ack) begin
        m_outstanding = 1;
        m_drain_addr  = m_pc;
      end
      m_pc = ba;
    end else if (m_held) begin
      if (!hz) begin
        m_v = 1; m_ipc = m_bpc + 32'd4; m_instr = m_binstr;
        m_pc = m_pc + 32'd4; m_held = 0;
      end
    end else if (m_outstanding) begin
      if (ack) m_outstanding = 0;
    end else if (ack) begin
      if (hz) begin
        m_held = 1; m_bpc = m_pc; m_binstr = rd;
      end else begin
        m_v = 1; m_ipc = m_pc + 32'd4; m_instr = rd; m_pc = m_pc + 32'd4;
      end
    end else if (!hz) begin
      m_v = 0;
    end
  endtask

  task automatic check_model(input int unsigned cyc);
    logic        e_req;
    logic [31:0] e_addr;
    e_req  = m_started && !m_held;
    e_addr = m_outstanding ? m_drain_addr : m_pc;
    chk($sformatf("rnd%0d_req", cyc),   imem_req,    e_req);
    chk($sformatf("rnd%0d_addr", cyc),  imem_addr,   e_addr);
    chk($sformatf("rnd%0d_valid", cyc), if_id_valid, m_v);
    chk($sformatf("rnd%0d_pc", cyc),    if_id_pc,    m_ipc);
    chk($sformatf("rnd%0d_instr", cyc), if_id_instr, m_instr);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    chk("reset_req",   imem_req,    0);
    chk("reset_valid", if_id_valid, 0);
    chk("reset_addr",  imem_addr,   0);
    chk("reset_pc",    if_id_pc,    0);
    chk("reset_instr", if_id_instr, 0);
    rst_n = 1'b1;
    #1;
    chk("idle_req", imem_req, 0);

    //               hz br ba            ack rd            req addr          v  pc       instr
    tbl[0]  = mk(0, 0, 32'h0,        0, 32'h0,        1, 32'h0,        0, 32'h0,   32'h0);
    tbl[1]  = mk(0, 0, 32'h0,        1, 32'hE0810002, 1, 32'h4,        1, 32'h4,   32'hE0810002);
    tbl[2]  = mk(0, 0, 32'h0,        1, 32'hE0810003, 1, 32'h8,        1, 32'h8,   32'hE0810003);
    tbl[3]  = mk(1, 0, 32'h0,        1, 32'hE0810004, 0, 32'h8,        1, 32'h8,   32'hE0810003);
    tbl[4]  = mk(1, 0, 32'h0,        0, 32'h0,        0, 32'h8,        1, 32'h8,   32'hE0810003);
    tbl[5]  = mk(1, 0, 32'h0,        0, 32'h0,        0, 32'h8,        1, 32'h8,   32'hE0810003);
    tbl[6]  = mk(0, 0, 32'h0,        0, 32'h0,        1, 32'hC,        1, 32'hC,   32'hE0810004);
    tbl[7]  = mk(0, 0, 32'h0,        0, 32'h0,        1, 32'hC,        0, 32'hC,   32'hE0810004);
    tbl[8]  = mk(1, 0, 32'h0,        1, 32'hAAAA0001, 0, 32'hC,        0, 32'hC,   32'hE0810004);
    tbl[9]  = mk(1, 1, 32'h100,      0, 32'h0,        1, 32'h100,      0, 32'hC,   32'hE0810004);
    tbl[10] = mk(0, 0, 32'h0,        1, 32'h11111111, 1, 32'h104,      1, 32'h104, 32'h11111111);
    tbl[11] = mk(0, 1, 32'h200,      0, 32'h0,        1, 32'h104,      0, 32'h104, 32'h11111111);
    tbl[12] = mk(0, 0, 32'h0,        0, 32'h0,        1, 32'h104,      0, 32'h104, 32'h11111111);
    tbl[13] = mk(0, 0, 32'h0,        1, 32'hDEAD0000, 1, 32'h200,      0, 32'h104, 32'h11111111);
    tbl[14] = mk(0, 0, 32'h0,        1, 32'h22222222, 1, 32'h204,      1, 32'h204, 32'h22222222);
    tbl[15] = mk(0, 1, 32'hFFFFFFFC, 1, 32'h33333333, 1, 32'hFFFFFFFC, 0, 32'h204, 32'h22222222);
    tbl[16] = mk(0, 0, 32'h0,        1, 32'h44444444, 1, 32'h0,        1, 32'h0,   32'h44444444);
    tbl[17] = mk(1, 0, 32'h0,        0, 32'h0,        1, 32'h0,        1, 32'h0,   32'h44444444);

    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].hz, tbl[i].br, tbl[i].ba, tbl[i].ack, tbl[i].rd);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("vec%0d_req", i),   imem_req,    tbl[i].e_req);
      chk($sformatf("vec%0d_addr", i),  imem_addr,   tbl[i].e_addr);
      chk($sformatf("vec%0d_valid", i), if_id_valid, tbl[i].e_v);
      chk($sformatf("vec%0d_pc", i),    if_id_pc,    tbl[i].e_pc);
      chk($sformatf("vec%0d_instr", i), if_id_instr, tbl[i].e_instr);
    end
`ifdef IF_PERF_CNT_EN
    chk("vec_stall_cycles", stall_cycles, 32'd6);
    chk("vec_flush_count",  {16'h0, flush_count}, 32'd3);
`endif

    // Asynchronous reset mid-request, then an ack arriving in IDLE must be dropped.
    drive(0, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_req",   imem_req,    0);
    chk("async_rst_valid", if_id_valid, 0);
    chk("async_rst_addr",  imem_addr,   0);
    @(negedge clk);
    drive(0, 0, 0, 1, 32'hBAD0BAD0);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("late_ack_valid", if_id_valid, 0);
    chk("late_ack_req",   imem_req,    1);
    chk("late_ack_addr",  imem_addr,   0);
    drive(0, 0, 0, 0, 0);

    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int unsigned c = 0; c < 3000; c++) begin
      logic        hz, br, ack;
      logic [31:0] ba, rd;
      check_model(c);
      hz  = ($urandom_range(0, 2) == 0);
      br  = ($urandom_range(0, 7) == 0);
      ack = ($urandom_range(0, 1) == 0);
      rd  = $urandom;
      ba  = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFF0 | ($urandom & 32'hC)) : ($urandom & ~32'h3);
      drive(hz, br, ba, ack, rd);
      model_step(hz, br, ba, ack, rd);
      @(posedge clk);
      @(negedge clk);
    end
    check_model(3000);
`ifdef IF_PERF_CNT_EN
    chk("rnd_stall_cycles", stall_cycles, m_stall);
    chk("rnd_flush_count",  {16'h0, flush_count}, m_flush);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
